// File: rtl/sparse_dot_engine.sv
// Sparse dot-product engine: merge-joins two index-sorted (index, value) streams
// and accumulates products of matching indices through a two-stage signed MAC.
module sparse_dot_engine #(
  parameter int IDX_W = 16,
  parameter int VAL_W = 16,
  parameter int ACC_W = 40,
  parameter int CNT_W = 16,
  parameter int SAT   = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [IDX_W-1:0] a_idx,
  input  logic [VAL_W-1:0] a_val,
  input  logic             a_last,
  input  logic             b_valid,
  output logic             b_ready,
  input  logic [IDX_W-1:0] b_idx,
  input  logic [VAL_W-1:0] b_val,
  input  logic             b_last,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [ACC_W-1:0] res_data,
  output logic [CNT_W-1:0] res_count,
  output logic             res_overflow,
  output logic             busy
);

  typedef enum logic [2:0] {RUN, DRAIN_A, DRAIN_B, FLUSH, DONE} state_t;

  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t                    state_q, state_d;
  logic signed [2*VAL_W-1:0] prod_q, prod_d;
  logic                      prod_vld_q, prod_vld_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      ovf_q, ovf_d;
  logic                      started_q, started_d;

  logic                      a_fire, b_fire;
  logic                      idx_eq, idx_lt;
  logic signed [ACC_W-1:0]   prod_ext;
  logic signed [ACC_W:0]     sum_wide;
  logic                      sum_ovf;
  logic                      res_fire;

  assign idx_eq   = (a_idx == b_idx);
  assign idx_lt   = (a_idx < b_idx);
  assign a_fire   = a_valid && a_ready;
  assign b_fire   = b_valid && b_ready;
  assign res_fire = (state_q == DONE) && res_ready;

  // Readies are forced low while reset is held so every output reads 0 during reset.
  always_comb begin
    a_ready = 1'b0;
    b_ready = 1'b0;
    case (state_q)
      RUN: begin
        if (a_valid && b_valid) begin
          a_ready = idx_eq || idx_lt;
          b_ready = idx_eq || !idx_lt;
        end
      end
      DRAIN_A: a_ready = 1'b1;
      DRAIN_B: b_ready = 1'b1;
      default: ;
    endcase
    if (!reset) begin
      a_ready = 1'b0;
      b_ready = 1'b0;
    end
  end

  always_comb begin
    state_d    = state_q;
    started_d  = started_q;
    prod_d     = prod_q;
    prod_vld_d = 1'b0;
    case (state_q)
      RUN: begin
        if (a_fire || b_fire) started_d = 1'b1;
        if (a_fire && b_fire) begin
          prod_d     = (2*VAL_W)'($signed(a_val)) * (2*VAL_W)'($signed(b_val));
          prod_vld_d = 1'b1;
        end
        if (a_fire && a_last && b_fire && b_last) state_d = FLUSH;
        else if (a_fire && a_last)               state_d = DRAIN_B;
        else if (b_fire && b_last)               state_d = DRAIN_A;
      end
      DRAIN_A: if (a_fire && a_last) state_d = FLUSH;
      DRAIN_B: if (b_fire && b_last) state_d = FLUSH;
      FLUSH:   state_d = DONE;
      DONE: begin
        if (res_ready) begin
          state_d   = RUN;
          started_d = 1'b0;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // One extra sign bit on the sum exposes signed overflow of the ACC_W-bit add.
  always_comb begin
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    prod_ext = ACC_W'(prod_q);
    sum_wide = (ACC_W+1)'(acc_q) + (ACC_W+1)'(prod_ext);
    sum_ovf  = sum_wide[ACC_W] != sum_wide[ACC_W-1];
    if (prod_vld_q) begin
      ovf_d = ovf_q | sum_ovf;
      if (sum_ovf && (SAT != 0)) acc_d = sum_wide[ACC_W] ? ACC_MIN : ACC_MAX;
      else                       acc_d = sum_wide[ACC_W-1:0];
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
    end
    if (res_fire) begin
      acc_d = '0;
      cnt_d = '0;
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= RUN;
      prod_q     <= '0;
      prod_vld_q <= 1'b0;
      acc_q      <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      started_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      prod_q     <= prod_d;
      prod_vld_q <= prod_vld_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      started_q  <= started_d;
    end
  end

  assign res_valid    = (state_q == DONE);
  assign res_data     = acc_q;
  assign res_count    = cnt_q;
  assign res_overflow = ovf_q;
  assign busy         = (state_q != RUN) || started_q;

endmodule

// File: tb/tb_sparse_dot_engine.sv
// Randomised bench for sparse_dot_engine: four instances (wide wrap, 32-bit saturating,
// 32-bit wrap, narrow counter) share one stimulus and are checked against a dot-product model.
module tb_sparse_dot_engine;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_valid, a_last, b_valid, b_last, res_ready;
  logic [15:0] a_idx, a_val, b_idx, b_val;

  logic        a_ready, b_ready, res_valid, res_overflow, busy;
  logic [39:0] res_data;
  logic [15:0] res_count;

  logic        a_ready_s, b_ready_s, res_valid_s, res_overflow_s, busy_s;
  logic [31:0] res_data_s;
  logic [15:0] res_count_s;
  logic        a_ready_w, b_ready_w, res_valid_w, res_overflow_w, busy_w;
  logic [31:0] res_data_w;
  logic [15:0] res_count_w;
  logic        a_ready_c, b_ready_c, res_valid_c, res_overflow_c, busy_c;
  logic [39:0] res_data_c;
  logic [1:0]  res_count_c;

  int n_vec = 0;
  int n_bad = 0;

  int qa_idx[$], qa_val[$], qb_idx[$], qb_val[$];

  logic [39:0] o_data;
  logic [15:0] o_cnt;
  logic        o_ovf, o_busy;
  logic [31:0] o_data_s, o_data_w;
  logic        o_ovf_s, o_ovf_w;
  logic [1:0]  o_cnt_c;

  always #5 clk = ~clk;

  sparse_dot_engine #(.IDX_W(16), .VAL_W(16), .ACC_W(40), .CNT_W(16), .SAT(0)) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_idx(a_idx), .a_val(a_val), .a_last(a_last),
    .b_valid(b_valid), .b_ready(b_ready), .b_idx(b_idx), .b_val(b_val), .b_last(b_last),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_count(res_count), .res_overflow(res_overflow), .busy(busy));

  sparse_dot_engine #(.IDX_W(16), .VAL_W(16), .ACC_W(32), .CNT_W(16), .SAT(1)) dut_s (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready_s), .a_idx(a_idx), .a_val(a_val), .a_last(a_last),
    .b_valid(b_valid), .b_ready(b_ready_s), .b_idx(b_idx), .b_val(b_val), .b_last(b_last),
    .res_valid(res_valid_s), .res_ready(res_ready), .res_data(res_data_s),
    .res_count(res_count_s), .res_overflow(res_overflow_s), .busy(busy_s));

  sparse_dot_engine #(.IDX_W(16), .VAL_W(16), .ACC_W(32), .CNT_W(16), .SAT(0)) dut_w (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready_w), .a_idx(a_idx), .a_val(a_val), .a_last(a_last),
    .b_valid(b_valid), .b_ready(b_ready_w), .b_idx(b_idx), .b_val(b_val), .b_last(b_last),
    .res_valid(res_valid_w), .res_ready(res_ready), .res_data(res_data_w),
    .res_count(res_count_w), .res_overflow(res_overflow_w), .busy(busy_w));

  sparse_dot_engine #(.IDX_W(16), .VAL_W(16), .ACC_W(40), .CNT_W(2), .SAT(0)) dut_c (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready_c), .a_idx(a_idx), .a_val(a_val), .a_last(a_last),
    .b_valid(b_valid), .b_ready(b_ready_c), .b_idx(b_idx), .b_val(b_val), .b_last(b_last),
    .res_valid(res_valid_c), .res_ready(res_ready), .res_data(res_data_c),
    .res_count(res_count_c), .res_overflow(res_overflow_c), .busy(busy_c));

  // Dot product over matching indices, accumulated term by term in ascending index order.
  function automatic void ref_model(input int acc_w, input bit sat,
                                    output longint data, output int cnt, output bit ovf);
    longint span, mx, mn, acc, p, s;
    span = longint'(1) <<< acc_w;
    mx   = span / 2 - 1;
    mn   = -(span / 2);
    acc  = 0;
    cnt  = 0;
    ovf  = 1'b0;
    for (int i = 0; i < qa_idx.size(); i++) begin
      for (int j = 0; j < qb_idx.size(); j++) begin
        if (qa_idx[i] == qb_idx[j]) begin
          p = longint'(qa_val[i]) * longint'(qb_val[j]);
          s = acc + p;
          if (s > mx || s < mn) begin
            ovf = 1'b1;
            if (sat)         s = (s > mx) ? mx : mn;
            else if (s > mx) s = s - span;
            else             s = s + span;
          end
          acc = s;
          cnt++;
        end
      end
    end
    data = acc;
  endfunction

  function automatic void clear_vecs();
    qa_idx.delete(); qa_val.delete(); qb_idx.delete(); qb_val.delete();
  endfunction

  function automatic void gen_random_pair();
    int n, idx;
    clear_vecs();
    n = $urandom_range(1, 8);
    idx = $urandom_range(0, 3);
    for (int k = 0; k < n; k++) begin
      qa_idx.push_back(idx);
      qa_val.push_back(int'($urandom_range(0, 65535)) - 32768);
      idx += $urandom_range(1, 3);
    end
    n = $urandom_range(1, 8);
    idx = $urandom_range(0, 3);
    for (int k = 0; k < n; k++) begin
      qb_idx.push_back(idx);
      qb_val.push_back(int'($urandom_range(0, 65535)) - 32768);
      idx += $urandom_range(1, 3);
    end
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    a_valid = 1'b0; b_valid = 1'b0; res_ready = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic drive_streams(input int pct, output bit to);
    int ai, bi, na, nb, guard;
    bit af, bf;
    ai = 0; bi = 0; guard = 0; to = 1'b0;
    na = qa_idx.size(); nb = qb_idx.size();
    while ((ai < na || bi < nb) && !to) begin
      @(negedge clk);
      a_valid = (ai < na) && ($urandom_range(0, 99) < pct);
      b_valid = (bi < nb) && ($urandom_range(0, 99) < pct);
      if (ai < na) begin
        a_idx = 16'(qa_idx[ai]); a_val = 16'(qa_val[ai]); a_last = (ai == na - 1);
      end
      if (bi < nb) begin
        b_idx = 16'(qb_idx[bi]); b_val = 16'(qb_val[bi]); b_last = (bi == nb - 1);
      end
      #1;
      af = a_valid && a_ready;
      bf = b_valid && b_ready;
      @(posedge clk);
      if (af) ai++;
      if (bf) bi++;
      guard++;
      if (guard > 2000) to = 1'b1;
    end
  endtask

  // Counts negedges from the final accepting edge until res_valid is seen.
  task automatic wait_result(output int lat, output bit to);
    lat = 0;
    to = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      a_valid = 1'b0;
      b_valid = 1'b0;
      lat++;
      if (res_valid) begin
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic capture();
    o_data = res_data; o_cnt = res_count; o_ovf = res_overflow; o_busy = busy;
    o_data_s = res_data_s; o_ovf_s = res_overflow_s;
    o_data_w = res_data_w; o_ovf_w = res_overflow_w;
    o_cnt_c = res_count_c;
  endtask

  task automatic handshake();
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    a_valid = 1'b0;
    b_valid = 1'b0;
  endtask

  task automatic run_pair(input int pct, input bit do_hs, output int lat, output bit to);
    bit to1, to2;
    to2 = 1'b0;
    lat = 0;
    drive_streams(pct, to1);
    if (!to1) wait_result(lat, to2);
    to = to1 | to2;
    if (!to) begin
      capture();
      if (do_hs) handshake();
    end else begin
      do_reset();
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    res_ready = 1'b0;
    a_valid = 1'b1; b_valid = 1'b1;
    a_idx = 16'd3; b_idx = 16'd3; a_val = 16'd1; b_val = 16'd1;
    a_last = 1'b0; b_last = 1'b0;
    #12;
    n_vec++; if (a_ready !== 1'b0) begin n_bad++; $display("FAIL reset_a_ready got %b want 0", a_ready); end
    n_vec++; if (b_ready !== 1'b0) begin n_bad++; $display("FAIL reset_b_ready got %b want 0", b_ready); end
    n_vec++; if (res_valid !== 1'b0) begin n_bad++; $display("FAIL reset_res_valid got %b want 0", res_valid); end
    n_vec++; if (res_data !== 40'd0) begin n_bad++; $display("FAIL reset_res_data got %0h want 0", res_data); end
    n_vec++; if (res_count !== 16'd0) begin n_bad++; $display("FAIL reset_res_count got %0d want 0", res_count); end
    n_vec++; if (res_overflow !== 1'b0) begin n_bad++; $display("FAIL reset_res_overflow got %b want 0", res_overflow); end
    n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
    @(negedge clk);
    a_valid = 1'b0; b_valid = 1'b0;
    reset = 1'b1;
    $display("reset: outputs checked while reset held");
  endtask

  task automatic test_basic();
    int lat; bit to;
    clear_vecs();
    qa_idx = '{1, 4, 7};  qa_val = '{2, 3, -5};
    qb_idx = '{4, 7, 9};  qb_val = '{10, 2, 1};
    run_pair(100, 1'b1, lat, to);
    n_vec++; if (to) begin n_bad++; $display("FAIL basic_timeout got no result want res_valid"); end
    else begin
      n_vec++; if (lat != 2) begin n_bad++; $display("FAIL basic_latency got %0d want 2", lat); end
      n_vec++; if (o_data !== 40'd20) begin n_bad++; $display("FAIL basic_data got %0d want 20", $signed(o_data)); end
      n_vec++; if (o_cnt !== 16'd2) begin n_bad++; $display("FAIL basic_count got %0d want 2", o_cnt); end
      n_vec++; if (o_ovf !== 1'b0) begin n_bad++; $display("FAIL basic_ovf got %b want 0", o_ovf); end
      n_vec++; if (o_busy !== 1'b1) begin n_bad++; $display("FAIL basic_busy_done got %b want 1", o_busy); end
      n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL basic_busy_idle got %b want 0", busy); end
    end
    $display("basic: data=%0d count=%0d latency=%0d", $signed(o_data), o_cnt, lat);
  endtask

  task automatic test_no_overlap();
    int lat; bit to;
    logic [39:0] exp40;
    clear_vecs();
    qa_idx = '{0}; qa_val = '{1};
    qb_idx = '{5}; qb_val = '{1};
    run_pair(100, 1'b1, lat, to);
    n_vec++; if (to) begin n_bad++; $display("FAIL disjoint_timeout got no result want res_valid"); end
    else begin
      n_vec++; if (o_data !== 40'd0) begin n_bad++; $display("FAIL disjoint_data got %0d want 0", $signed(o_data)); end
      n_vec++; if (o_cnt !== 16'd0) begin n_bad++; $display("FAIL disjoint_count got %0d want 0", o_cnt); end
    end
    $display("disjoint: data=%0d count=%0d", $signed(o_data), o_cnt);
    clear_vecs();
    qa_idx = '{3}; qa_val = '{-4};
    qb_idx = '{3}; qb_val = '{6};
    exp40 = -40'sd24;
    run_pair(100, 1'b1, lat, to);
    n_vec++; if (to) begin n_bad++; $display("FAIL joint_last_timeout got no result want res_valid"); end
    else begin
      n_vec++; if (lat != 2) begin n_bad++; $display("FAIL joint_last_latency got %0d want 2", lat); end
      n_vec++; if (o_data !== exp40) begin n_bad++; $display("FAIL joint_last_data got %0d want -24", $signed(o_data)); end
      n_vec++; if (o_cnt !== 16'd1) begin n_bad++; $display("FAIL joint_last_count got %0d want 1", o_cnt); end
    end
    $display("joint_last: data=%0d count=%0d latency=%0d", $signed(o_data), o_cnt, lat);
  endtask

  task automatic test_saturation();
    int lat; bit to;
    logic [31:0] exp_w;
    logic [39:0] exp_wide;
    clear_vecs();
    qa_idx = '{0, 1, 2}; qa_val = '{32767, 32767, 32767};
    qb_idx = '{0, 1, 2}; qb_val = '{32767, 32767, 32767};
    exp_w = -32'sd1073938429;
    exp_wide = 40'd3221028867;
    run_pair(100, 1'b1, lat, to);
    n_vec++; if (to) begin n_bad++; $display("FAIL sat_timeout got no result want res_valid"); end
    else begin
      n_vec++; if (o_data_s !== 32'h7FFF_FFFF) begin n_bad++; $display("FAIL sat_data got %0d want 2147483647", $signed(o_data_s)); end
      n_vec++; if (o_ovf_s !== 1'b1) begin n_bad++; $display("FAIL sat_ovf got %b want 1", o_ovf_s); end
      n_vec++; if (o_data_w !== exp_w) begin n_bad++; $display("FAIL wrap_data got %0d want -1073938429", $signed(o_data_w)); end
      n_vec++; if (o_ovf_w !== 1'b1) begin n_bad++; $display("FAIL wrap_ovf got %b want 1", o_ovf_w); end
      n_vec++; if (o_data !== exp_wide) begin n_bad++; $display("FAIL wide_data got %0d want 3221028867", o_data); end
      n_vec++; if (o_ovf !== 1'b0) begin n_bad++; $display("FAIL wide_ovf got %b want 0", o_ovf); end
    end
    $display("saturation: sat=%0d wrap=%0d wide=%0d", $signed(o_data_s), $signed(o_data_w), o_data);
  endtask

  task automatic test_backpressure();
    int lat; bit to; bit bad;
    logic [39:0] held;
    clear_vecs();
    qa_idx = '{2, 3}; qa_val = '{5, 7};
    qb_idx = '{3};    qb_val = '{4};
    run_pair(100, 1'b0, lat, to);
    n_vec++; if (to) begin n_bad++; $display("FAIL bp_timeout got no result want res_valid"); end
    else begin
      n_vec++; if (o_data !== 40'd28) begin n_bad++; $display("FAIL bp_first_data got %0d want 28", $signed(o_data)); end
      held = o_data;
      for (int k = 0; k < 10; k++) begin
        @(negedge clk);
        a_valid = 1'b1; b_valid = 1'b1;
        a_idx = 16'd9; b_idx = 16'd9; a_val = 16'd100; b_val = 16'd100;
        a_last = 1'b1; b_last = 1'b1;
        #1;
        bad = (res_valid !== 1'b1) || (a_ready !== 1'b0) || (b_ready !== 1'b0) ||
              (res_data !== 40'd28) || (res_count !== 16'd1);
        n_vec++;
        if (bad) begin
          n_bad++;
          $display("FAIL bp_hold cycle %0d got valid=%b ar=%b br=%b data=%0d cnt=%0d want 1 0 0 28 1",
                   k, res_valid, a_ready, b_ready, res_data, res_count);
        end
      end
      handshake();
      $display("backpressure: held data=%0d for 10 cycles", held);
      clear_vecs();
      qa_idx = '{3};    qa_val = '{2};
      qb_idx = '{3, 4}; qb_val = '{3, 1};
      run_pair(100, 1'b1, lat, to);
      n_vec++; if (to) begin n_bad++; $display("FAIL bp_second_timeout got no result want res_valid"); end
      else begin
        n_vec++; if (o_data !== 40'd6) begin n_bad++; $display("FAIL bp_second_data got %0d want 6", $signed(o_data)); end
        n_vec++; if (o_cnt !== 16'd1) begin n_bad++; $display("FAIL bp_second_count got %0d want 1", o_cnt); end
      end
      $display("backpressure: second data=%0d count=%0d", $signed(o_data), o_cnt);
    end
  endtask

  task automatic test_random();
    int lat; bit to;
    longint m_data, m_data_s, m_data_w;
    int m_cnt, m_cnt_s, m_cnt_w, m_cnt_c;
    bit m_ovf, m_ovf_s, m_ovf_w;
    for (int p = 0; p < 200; p++) begin
      gen_random_pair();
      ref_model(40, 1'b0, m_data, m_cnt, m_ovf);
      ref_model(32, 1'b1, m_data_s, m_cnt_s, m_ovf_s);
      ref_model(32, 1'b0, m_data_w, m_cnt_w, m_ovf_w);
      m_cnt_c = (m_cnt > 3) ? 3 : m_cnt;
      run_pair(50, 1'b1, lat, to);
      n_vec++;
      if (to) begin
        n_bad++;
        $display("FAIL rand_timeout pair %0d got no result want res_valid", p);
        continue;
      end
      if (lat != 2 || o_data !== m_data[39:0] || o_cnt !== 16'(m_cnt) || o_ovf !== m_ovf) begin
        n_bad++;
        $display("FAIL rand_wide pair %0d got lat=%0d data=%0d cnt=%0d ovf=%b want lat=2 data=%0d cnt=%0d ovf=%b",
                 p, lat, $signed(o_data), o_cnt, o_ovf, m_data, m_cnt, m_ovf);
      end
      n_vec++;
      if (o_data_s !== m_data_s[31:0] || o_ovf_s !== m_ovf_s) begin
        n_bad++;
        $display("FAIL rand_sat32 pair %0d got data=%0d ovf=%b want data=%0d ovf=%b",
                 p, $signed(o_data_s), o_ovf_s, m_data_s, m_ovf_s);
      end
      n_vec++;
      if (o_data_w !== m_data_w[31:0] || o_ovf_w !== m_ovf_w) begin
        n_bad++;
        $display("FAIL rand_wrap32 pair %0d got data=%0d ovf=%b want data=%0d ovf=%b",
                 p, $signed(o_data_w), o_ovf_w, m_data_w, m_ovf_w);
      end
      n_vec++;
      if (o_cnt_c !== 2'(m_cnt_c)) begin
        n_bad++;
        $display("FAIL rand_cnt_sat pair %0d got %0d want %0d", p, o_cnt_c, m_cnt_c);
      end
      $display("pair %0d: na=%0d nb=%0d data=%0d count=%0d ovf=%b",
               p, qa_idx.size(), qb_idx.size(), $signed(o_data), o_cnt, o_ovf);
    end
  endtask

  task automatic test_reset_mid();
    int lat; bit to; bit seen;
    longint m_data; int m_cnt; bit m_ovf;
    logic [39:0] exp_p0;
    clear_vecs();
    for (int k = 0; k < 5; k++) begin
      qa_idx.push_back(2 * k); qa_val.push_back(int'($urandom_range(1, 1000)));
      qb_idx.push_back(2 * k); qb_val.push_back(int'($urandom_range(1, 1000)));
    end
    exp_p0 = 40'(qa_val[0] * qb_val[0]);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      a_valid = 1'b1; b_valid = 1'b1;
      a_idx = 16'(qa_idx[k]); a_val = 16'(qa_val[k]); a_last = 1'b0;
      b_idx = 16'(qb_idx[k]); b_val = 16'(qb_val[k]); b_last = 1'b0;
      @(posedge clk);
    end
    @(negedge clk);
    a_idx = 16'(qa_idx[2]); a_val = 16'(qa_val[2]);
    b_idx = 16'(qb_idx[2]); b_val = 16'(qb_val[2]);
    n_vec++; if (res_data !== exp_p0) begin n_bad++; $display("FAIL mid_partial_sum got %0d want %0d", res_data, exp_p0); end
    n_vec++; if (busy !== 1'b1) begin n_bad++; $display("FAIL mid_busy got %b want 1", busy); end
    reset = 1'b0;
    #1;
    n_vec++; if (a_ready !== 1'b0 || b_ready !== 1'b0) begin n_bad++; $display("FAIL mid_reset_ready got %b%b want 00", a_ready, b_ready); end
    n_vec++; if (res_data !== 40'd0 || res_count !== 16'd0 || res_overflow !== 1'b0) begin
      n_bad++; $display("FAIL mid_reset_result got data=%0d cnt=%0d ovf=%b want 0 0 0", res_data, res_count, res_overflow);
    end
    n_vec++; if (res_valid !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL mid_reset_status got valid=%b busy=%b want 0 0", res_valid, busy); end
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (res_valid) seen = 1'b1;
    end
    reset = 1'b1;
    a_valid = 1'b0; b_valid = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (res_valid) seen = 1'b1;
    end
    n_vec++; if (seen) begin n_bad++; $display("FAIL mid_no_result got res_valid=1 want 0"); end
    $display("reset_mid: partial result discarded");
    gen_random_pair();
    ref_model(40, 1'b0, m_data, m_cnt, m_ovf);
    run_pair(100, 1'b1, lat, to);
    n_vec++;
    if (to) begin n_bad++; $display("FAIL mid_fresh_timeout got no result want res_valid"); end
    else if (o_data !== m_data[39:0] || o_cnt !== 16'(m_cnt)) begin
      n_bad++;
      $display("FAIL mid_fresh got data=%0d cnt=%0d want data=%0d cnt=%0d", $signed(o_data), o_cnt, m_data, m_cnt);
    end
    $display("reset_mid: fresh pair data=%0d count=%0d", $signed(o_data), o_cnt);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_no_overlap();
    test_saturation();
    test_backpressure();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got no completion want finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
